// File: rtl/gr8bit_uart_pkg.sv
// Shared definitions for the gr8bit 8N1 UART: state encodings, frame
// geometry and the default bit period.
package gr8bit_uart_pkg;

    // Payload bits per frame and the index of the last one.
    localparam int         DATA_BITS = 8;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    // full_clk cycles per serial bit when the parent does not override it.
    localparam logic [7:0] DEFAULT_CLKS_PER_BIT = 8'd8;

    // Receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Transmitter states.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Delay from the detected start edge to the middle of the start bit.
    function automatic logic [7:0] half_bit(input logic [7:0] clks_per_bit);
        return clks_per_bit >> 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter. 'clear' restarts the period; 'done'
// pulses on the last cycle of each period of 'limit' cycles, after which
// the count wraps to zero on its own.
module uart_bit_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] limit,
    output logic       done
);

    logic [7:0] count;

    // Terminal count; '>=' keeps the timer sane if limit shrinks mid-period.
    assign done = (count >= (limit - 8'd1));

    // Count cycles, restarting on clear or at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear || done) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART for the gr8bit CPU: independent receiver and transmitter on
// full_clk, with a byte-wide CPU interface qualified by cpu_clk edges.
//
// CPU handshake:
//   - Transmit: a request is taken on a cpu_tick where set_send is 1, was 0
//     on the previous cpu_tick, and the transmitter is idle. Requests made
//     while busy are dropped; holding set_send high sends one byte only.
//   - Receive: get_recv is the valid flag for recv_out. It is set when a
//     frame with a good stop bit completes and cleared by a cpu_tick with
//     set_recv_clear=1. A completing frame beats a simultaneous clear, and
//     a new frame overwrites an unread byte (get_recv stays 1).
module uart
    import gr8bit_uart_pkg::*;
#(
    parameter logic [7:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       full_clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic       cpu_clk,
    input  logic [7:0] send_in,
    input  logic       set_send,
    input  logic       set_recv_clear,
    output logic [7:0] recv_out,
    output logic       get_recv
);

    // ---------------------------------------------------------------
    // CPU phase edge detection
    // ---------------------------------------------------------------
    logic cpu_prev;
    logic cpu_tick;
    logic set_send_prev;

    assign cpu_tick = cpu_clk & ~cpu_prev;

    // Remember the previous cpu_clk sample and the set_send seen at the last tick.
    always_ff @(posedge full_clk) begin
        if (rst) begin
            cpu_prev      <= 1'b0;
            set_send_prev <= 1'b0;
        end else begin
            cpu_prev <= cpu_clk;
            if (cpu_tick) begin
                set_send_prev <= set_send;
            end
        end
    end

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------
    logic       rx_meta;
    logic       rx_sync;
    rx_state_t  rx_state;
    rx_state_t  rx_next;
    logic [2:0] rx_bit_idx;
    logic [7:0] rx_shift;
    logic [7:0] rx_limit;
    logic       rx_timer_clear;
    logic       rx_timer_done;
    logic       rx_shift_en;
    logic       rx_commit;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge full_clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    uart_bit_timer u_rx_timer (
        .clk   (full_clk),
        .rst   (rst),
        .clear (rx_timer_clear),
        .limit (rx_limit),
        .done  (rx_timer_done)
    );

    // RX next-state: find the start edge, confirm it mid-bit, then sample mid-bit.
    always_comb begin
        rx_next        = rx_state;
        rx_limit       = CLKS_PER_BIT;
        rx_timer_clear = 1'b0;
        rx_shift_en    = 1'b0;
        rx_commit      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_timer_clear = 1'b1;
                if (!rx_sync) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                rx_limit = half_bit(CLKS_PER_BIT);
                if (rx_timer_done) begin
                    rx_timer_clear = 1'b1;
                    rx_next        = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_timer_done) begin
                    rx_timer_clear = 1'b1;
                    rx_shift_en    = 1'b1;
                    if (rx_bit_idx == LAST_BIT) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_timer_done) begin
                    rx_timer_clear = 1'b1;
                    rx_commit      = rx_sync;
                    rx_next        = RX_IDLE;
                end
            end
            default: begin
                rx_next = RX_IDLE;
            end
        endcase
    end

    // RX state, shift register and the CPU-visible byte/valid flag.
    always_ff @(posedge full_clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_bit_idx <= 3'd0;
            rx_shift   <= 8'h00;
            recv_out   <= 8'h00;
            get_recv   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_shift_en) begin
                rx_shift   <= {rx_sync, rx_shift[7:1]};
                rx_bit_idx <= rx_bit_idx + 3'd1;
            end else if (rx_state == RX_IDLE) begin
                rx_bit_idx <= 3'd0;
            end
            if (rx_commit) begin
                recv_out <= rx_shift;
                get_recv <= 1'b1;
            end else if (cpu_tick && set_recv_clear) begin
                get_recv <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------
    tx_state_t  tx_state;
    tx_state_t  tx_next;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit_idx;
    logic       tx_timer_clear;
    logic       tx_timer_done;
    logic       tx_accept;
    logic       tx_load;
    logic       tx_shift_en;
    logic       tx_line_d;

    assign tx_accept = cpu_tick & set_send & ~set_send_prev & (tx_state == TX_IDLE);

    uart_bit_timer u_tx_timer (
        .clk   (full_clk),
        .rst   (rst),
        .clear (tx_timer_clear),
        .limit (CLKS_PER_BIT),
        .done  (tx_timer_done)
    );

    // TX next-state and next line level; the line itself is registered.
    always_comb begin
        tx_next        = tx_state;
        tx_timer_clear = 1'b0;
        tx_load        = 1'b0;
        tx_shift_en    = 1'b0;
        tx_line_d      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_timer_clear = 1'b1;
                if (tx_accept) begin
                    tx_load   = 1'b1;
                    tx_line_d = 1'b0;
                    tx_next   = TX_START;
                end
            end
            TX_START: begin
                tx_line_d = 1'b0;
                if (tx_timer_done) begin
                    tx_line_d = tx_shift[0];
                    tx_next   = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_line_d = tx_shift[0];
                if (tx_timer_done) begin
                    tx_shift_en = 1'b1;
                    if (tx_bit_idx == LAST_BIT) begin
                        tx_line_d = 1'b1;
                        tx_next   = TX_STOP;
                    end else begin
                        tx_line_d = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                tx_line_d = 1'b1;
                if (tx_timer_done) begin
                    tx_next = TX_IDLE;
                end
            end
            default: begin
                tx_next = TX_IDLE;
            end
        endcase
    end

    // TX state, latched byte and the glitch-free output flop.
    always_ff @(posedge full_clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_shift   <= 8'h00;
            tx_bit_idx <= 3'd0;
            uart_tx    <= 1'b1;
        end else begin
            tx_state <= tx_next;
            uart_tx  <= tx_line_d;
            if (tx_load) begin
                tx_shift   <= send_in;
                tx_bit_idx <= 3'd0;
            end else if (tx_shift_en) begin
                tx_shift   <= {1'b0, tx_shift[7:1]};
                tx_bit_idx <= tx_bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart.sv
// Bench for the gr8bit UART: directed scenarios plus randomized frames,
// checked against a frame-level model of the serial protocol.
module tb_uart;

    localparam int CPB = 8;

    // ---------------- clock / reset / DUT ----------------
    logic       full_clk = 1'b0;
    logic       cpu_clk  = 1'b0;
    logic       rst;
    logic       rx_drv;
    logic       loop_en;
    logic       rx_pin;
    logic       uart_tx;
    logic [7:0] send_in;
    logic       set_send;
    logic       set_recv_clear;
    logic [7:0] recv_out;
    logic       get_recv;

    always #1 full_clk = ~full_clk;
    always #4 cpu_clk  = ~cpu_clk;

    assign rx_pin = loop_en ? uart_tx : rx_drv;

    uart #(.CLKS_PER_BIT(8'd8)) dut (
        .full_clk       (full_clk),
        .rst            (rst),
        .uart_rx        (rx_pin),
        .uart_tx        (uart_tx),
        .cpu_clk        (cpu_clk),
        .send_in        (send_in),
        .set_send       (set_send),
        .set_recv_clear (set_recv_clear),
        .recv_out       (recv_out),
        .get_recv       (get_recv)
    );

    // ---------------- scoreboard / model ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_recv;
    logic       exp_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    // Latest good frame wins; any completed frame marks the byte valid.
    task automatic sb_update();
        while (exp_q.size() > 0) begin
            exp_recv  = exp_q.pop_front();
            exp_valid = 1'b1;
        end
    endtask

    // Serial level of bit slot idx of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic rx_frame(input logic [7:0] b, input logic stop, input int gap);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                check_eq("rx_early_valid", get_recv, exp_valid);
                check_eq("rx_early_data", recv_out, exp_recv);
            end
            rx_drv = (i == 9) ? stop : frame_bit(b, i);
            repeat (CPB) @(negedge full_clk);
        end
        rx_drv = 1'b1;
        if (stop) exp_q.push_back(b);
        sb_update();
        check_eq("rx_data", recv_out, exp_recv);
        check_eq("rx_valid", get_recv, exp_valid);
        repeat (gap) @(negedge full_clk);
    endtask

    task automatic rx_glitch(input int len);
        rx_drv = 1'b0;
        repeat (len) @(negedge full_clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge full_clk);
        check_eq("glitch_valid", get_recv, exp_valid);
        check_eq("glitch_data", recv_out, exp_recv);
    endtask

    task automatic recv_clear();
        set_recv_clear = 1'b1;
        repeat (5) @(negedge full_clk);
        set_recv_clear = 1'b0;
        exp_valid = 1'b0;
        check_eq("clear_valid", get_recv, exp_valid);
        check_eq("clear_data", recv_out, exp_recv);
    endtask

    // mode 0: short request; 1: request held through the frame;
    // 2: short request plus a second request (0x55) while busy.
    task automatic tx_send(input logic [7:0] b, input int mode);
        int lat;
        send_in  = b;
        set_send = 1'b1;
        lat      = 0;
        while (uart_tx === 1'b1 && lat < 12) begin
            @(negedge full_clk);
            lat++;
        end
        if (uart_tx !== 1'b0) begin
            check_eq("tx_start_timeout", uart_tx, 0);
            set_send = 1'b0;
            return;
        end
        check_eq("tx_latency", (lat >= 1 && lat <= 5), 1);
        for (int c = 0; c < 10 * CPB; c++) begin
            check_eq("tx_bit", uart_tx, frame_bit(b, c / CPB));
            if (mode != 1 && c == 4) set_send = 1'b0;
            if (mode == 2 && c == 20) begin
                send_in  = 8'h55;
                set_send = 1'b1;
            end
            if (mode == 2 && c == 28) set_send = 1'b0;
            @(negedge full_clk);
        end
        for (int c = 0; c < 3 * CPB; c++) begin
            check_eq("tx_idle", uart_tx, 1);
            @(negedge full_clk);
        end
        set_send = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        logic       stp;
        int         gap;

        rst            = 1'b1;
        rx_drv         = 1'b1;
        loop_en        = 1'b0;
        send_in        = 8'h00;
        set_send       = 1'b0;
        set_recv_clear = 1'b0;
        exp_recv       = 8'h00;
        exp_valid      = 1'b0;
        repeat (4) @(negedge full_clk);
        rst = 1'b0;
        @(negedge full_clk);

        // Reset state
        check_eq("rst_tx", uart_tx, 1);
        check_eq("rst_data", recv_out, 8'h00);
        check_eq("rst_valid", get_recv, 0);

        // Receive 'a', then clear it
        rx_frame(8'h61, 1'b1, 2 * CPB);
        recv_clear();

        // Transmit 'A'; then 'A' with a dropped busy request; then a held request
        tx_send(8'h41, 0);
        tx_send(8'h41, 2);
        tx_send(8'($urandom()), 1);

        // Glitches and a framing error leave the byte untouched
        rx_glitch(4);
        rx_glitch($urandom_range(1, 3));
        rx_frame(8'($urandom()), 1'b0, 2 * CPB);

        // Back-to-back overrun: second byte wins, flag stays set
        rx_frame(8'($urandom()), 1'b1, 0);
        rx_frame(8'($urandom()), 1'b1, 2 * CPB);
        recv_clear();

        // Randomized receive traffic with occasional clears
        for (int n = 0; n < 10; n++) begin
            b   = 8'($urandom());
            stp = ($urandom_range(0, 9) != 0);
            gap = stp ? $urandom_range(0, 12) : 2 * CPB;
            rx_frame(b, stp, gap);
            if ($urandom_range(0, 2) == 0) recv_clear();
        end

        // Full duplex: one frame each way at the same time
        for (int n = 0; n < 2; n++) begin
            fork
                tx_send(8'($urandom()), 0);
                rx_frame(8'($urandom()), 1'b1, 2 * CPB);
            join
        end

        // Randomized transmit traffic
        for (int n = 0; n < 3; n++) begin
            tx_send(8'($urandom()), $urandom_range(0, 2));
        end

        // Reset in the middle of a transmit frame
        send_in  = 8'h00;
        set_send = 1'b1;
        repeat (30) @(negedge full_clk);
        set_send = 1'b0;
        check_eq("pre_rst_busy", uart_tx, 0);
        rst = 1'b1;
        @(negedge full_clk);
        check_eq("rst_mid_tx", uart_tx, 1);
        check_eq("rst_mid_data", recv_out, 8'h00);
        check_eq("rst_mid_valid", get_recv, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_recv  = 8'h00;
        exp_valid = 1'b0;
        repeat (12) @(negedge full_clk);
        check_eq("post_rst_idle", uart_tx, 1);

        // Loopback: transmitter feeds the receiver
        loop_en = 1'b1;
        tx_send(8'hA5, 0);
        exp_q.push_back(8'hA5);
        sb_update();
        check_eq("loop_data", recv_out, exp_recv);
        check_eq("loop_valid", get_recv, exp_valid);
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom());
            tx_send(b, 0);
            exp_q.push_back(b);
            sb_update();
            check_eq("loop_rand_data", recv_out, exp_recv);
            check_eq("loop_rand_valid", get_recv, exp_valid);
        end
        loop_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
